// File: rtl/status_reg.sv
// Per-core Z/N/C status flags with registered all/any-zero summaries and a saturating
// zero-result counter. Define STATUS_STICKY_ZERO_EN to add per-core sticky zero-seen bits.
module status_reg #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CORES = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CORES*WIDTH-1:0] dataIn,
  input  logic [CORES-1:0]       carryIn,
  input  logic [CORES-1:0]       wrEn,
  input  logic                   clrEn,
  output logic [CORES-1:0]       Zout,
  output logic [CORES-1:0]       Nout,
  output logic [CORES-1:0]       Cout,
  output logic                   allZero,
  output logic                   anyZero,
  output logic [CORES-1:0]       stickyZ,
  output logic [CNT_W-1:0]       zCount
);

  // Headroom for adding up to 16 core increments before clamping.
  localparam int unsigned SumW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CORES-1:0] zout_q, zout_d;
  logic [CORES-1:0] nout_q, nout_d;
  logic [CORES-1:0] cout_q, cout_d;
  logic             all_zero_q, all_zero_d;
  logic             any_zero_q, any_zero_d;
  logic [CNT_W-1:0] zcount_q, zcount_d;
  logic [CORES-1:0] word_zero;
  logic [CORES-1:0] zero_wr;
  logic [SumW-1:0]  inc;
  logic [SumW-1:0]  sum;

  always_comb begin
    word_zero = '0;
    zout_d    = zout_q;
    nout_d    = nout_q;
    cout_d    = cout_q;
    for (int i = 0; i < int'(CORES); i++) begin
      word_zero[i] = (dataIn[i*WIDTH +: WIDTH] == '0);
      if (wrEn[i]) begin
        zout_d[i] = word_zero[i];
        nout_d[i] = dataIn[i*WIDTH + WIDTH - 1];
        cout_d[i] = carryIn[i];
      end
    end
    all_zero_d = &zout_d;
    any_zero_d = |zout_d;
  end

  assign zero_wr = wrEn & word_zero;

  always_comb begin
    inc = '0;
    for (int i = 0; i < int'(CORES); i++) begin
      inc = inc + SumW'(zero_wr[i]);
    end
    sum = SumW'(zcount_q) + inc;
    if (clrEn) begin
      zcount_d = '0;
    end else if (sum > SumW'(CntMax)) begin
      zcount_d = CntMax;
    end else begin
      zcount_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zout_q     <= '0;
      nout_q     <= '0;
      cout_q     <= '0;
      all_zero_q <= 1'b0;
      any_zero_q <= 1'b0;
      zcount_q   <= '0;
    end else begin
      zout_q     <= zout_d;
      nout_q     <= nout_d;
      cout_q     <= cout_d;
      all_zero_q <= all_zero_d;
      any_zero_q <= any_zero_d;
      zcount_q   <= zcount_d;
    end
  end

`ifdef STATUS_STICKY_ZERO_EN
  logic [CORES-1:0] sticky_q, sticky_d;

  // Clear wins over a same-cycle zero write.
  assign sticky_d = clrEn ? '0 : (sticky_q | zero_wr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign stickyZ = sticky_q;
`else
  assign stickyZ = '0;
`endif

  assign Zout    = zout_q;
  assign Nout    = nout_q;
  assign Cout    = cout_q;
  assign allZero = all_zero_q;
  assign anyZero = any_zero_q;
  assign zCount  = zcount_q;

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg (WIDTH=12, CORES=4, CNT_W=3): directed vectors with
// hand-computed expectations, then random traffic against a reference model.
module tb_status_reg;

`ifdef STATUS_STICKY_ZERO_EN
  localparam bit StickyOn = 1'b1;
`else
  localparam bit StickyOn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] z;
    logic [3:0] n;
    logic [3:0] c;
    logic       all;
    logic       any;
    logic [3:0] st;
    logic [2:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] dataIn = '0;
  logic [3:0]  carryIn = '0;
  logic [3:0]  wrEn = '0;
  logic        clrEn = 1'b0;
  logic [3:0]  Zout, Nout, Cout, stickyZ;
  logic        allZero, anyZero;
  logic [2:0]  zCount;

  status_reg #(.WIDTH(12), .CORES(4), .CNT_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .dataIn  (dataIn),
    .carryIn (carryIn),
    .wrEn    (wrEn),
    .clrEn   (clrEn),
    .Zout    (Zout),
    .Nout    (Nout),
    .Cout    (Cout),
    .allZero (allZero),
    .anyZero (anyZero),
    .stickyZ (stickyZ),
    .zCount  (zCount)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  event async_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [3:0] m_z = '0, m_n = '0, m_c = '0, m_st = '0;
  logic       m_all = 1'b0, m_any = 1'b0;
  int         m_cnt = 0;

  function automatic exp_t mk(input logic [3:0] z, input logic [3:0] n, input logic [3:0] c,
                              input logic all, input logic any, input logic [3:0] st,
                              input logic [2:0] cnt);
    exp_t e;
    e.z = z; e.n = n; e.c = c; e.all = all; e.any = any;
    e.st = StickyOn ? st : 4'b0000;
    e.cnt = cnt;
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic model_step(input logic r, input logic [3:0] wr, input logic [47:0] d,
                            input logic [3:0] cy, input logic cl);
    logic [3:0] zw;
    int inc;
    if (!r) begin
      m_z = '0; m_n = '0; m_c = '0; m_st = '0; m_all = 1'b0; m_any = 1'b0; m_cnt = 0;
    end else begin
      inc = 0;
      for (int i = 0; i < 4; i++) begin
        zw[i] = wr[i] && (d[i*12 +: 12] == 12'h000);
        if (zw[i]) inc++;
        if (wr[i]) begin
          m_z[i] = (d[i*12 +: 12] == 12'h000);
          m_n[i] = d[i*12 + 11];
          m_c[i] = cy[i];
        end
      end
      m_all = &m_z;
      m_any = |m_z;
      if (cl) m_cnt = 0;
      else m_cnt = (m_cnt + inc > 7) ? 7 : m_cnt + inc;
      if (StickyOn) m_st = cl ? 4'b0000 : (m_st | zw);
    end
  endtask

  // Drive one cycle of stimulus; expectation comes from hand values or the model.
  task automatic step(input logic r, input logic [3:0] wr, input logic [47:0] d,
                      input logic [3:0] cy, input logic cl, input bit use_hand,
                      input exp_t hand);
    @(negedge clk);
    rst = r; wrEn = wr; dataIn = d; carryIn = cy; clrEn = cl;
    model_step(r, wr, d, cy, cl);
    if (use_hand) exp_q.push_back(hand);
    else exp_q.push_back(mk(m_z, m_n, m_c, m_all, m_any, m_st, 3'(m_cnt)));
    if (!r) ->async_ev;
  endtask

  // Monitor: reset expectations are checked right after the negedge that asserts rst,
  // all others one time unit after the capturing posedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("Zout",    8'(Zout),    8'(e.z));
        check("Nout",    8'(Nout),    8'(e.n));
        check("Cout",    8'(Cout),    8'(e.c));
        check("allZero", 8'(allZero), 8'(e.all));
        check("anyZero", 8'(anyZero), 8'(e.any));
        check("stickyZ", 8'(stickyZ), 8'(e.st));
        check("zCount",  8'(zCount),  8'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] d;
    exp_t none;
    none = '0;
    // Reset held from time zero
    step(1'b0, 4'b0000, 48'h0, 4'b0000, 1'b0, 1, mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 3'd0));
    // Flags: words core0..3 = 0x800, 0, 0x001, 0
    step(1'b1, 4'b1111, {12'h000, 12'h001, 12'h000, 12'h800}, 4'b0101, 1'b0, 1,
         mk(4'b1010, 4'b0001, 4'b0101, 0, 1, 4'b1010, 3'd2));
    // All zero, then hold with 0xFFF and no write enables
    step(1'b1, 4'b1111, 48'h0, 4'b0000, 1'b0, 1,
         mk(4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b1111, 3'd6));
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0000, {4{12'hFFF}}, 4'b1111, 1'b0, 1,
           mk(4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b1111, 3'd6));
    end
    // Saturation: 6 + 4 clamps to 7, and stays there
    step(1'b1, 4'b1111, 48'h0, 4'b0000, 1'b0, 1,
         mk(4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b1111, 3'd7));
    step(1'b1, 4'b1111, 48'h0, 4'b0000, 1'b0, 1,
         mk(4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b1111, 3'd7));
    // Clear priority over a same-cycle zero write
    step(1'b1, 4'b0001, {{3{12'hFFF}}, 12'h000}, 4'b0000, 1'b1, 1,
         mk(4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000, 3'd0));
    step(1'b1, 4'b0001, {{3{12'hFFF}}, 12'h123}, 4'b0001, 1'b0, 1,
         mk(4'b1110, 4'b0000, 4'b0001, 0, 1, 4'b0000, 3'd0));
    // Mid-run reset with flags set, then first edge after release
    step(1'b0, 4'b1111, 48'h0, 4'b1111, 1'b0, 1, mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 3'd0));
    step(1'b0, 4'b1111, 48'h0, 4'b1111, 1'b0, 1, mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 3'd0));
    step(1'b1, 4'b0001, {{3{12'hFFF}}, 12'h000}, 4'b0000, 1'b0, 1,
         mk(4'b0001, 4'b0000, 4'b0000, 0, 1, 4'b0001, 3'd1));
    // Random traffic against the model
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 4; i++) begin
        d[i*12 +: 12] = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
      end
      step(($urandom_range(0, 31) != 0), 4'($urandom), d, 4'($urandom),
           ($urandom_range(0, 7) == 0), 0, none);
    end
    @(negedge clk);
    rst = 1'b1; wrEn = '0; clrEn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 12: data word width per core.
REQ-002 SHALL have parameter CORES, default 4: number of independent core channels, range 1..16.
REQ-003 SHALL have parameter CNT_W, default 8: width of the zero-event counter.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port dataIn, input, CORES*WIDTH bits: ALU result of core i in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port carryIn, input, CORES bits: carry out of the ALU of core i.
REQ-008 SHALL have port wrEn, input, CORES bits: per-core flag write enable.
REQ-009 SHALL have port clrEn, input, 1 bit: synchronous clear of the sticky and counter state.
REQ-010 SHALL have port Zout, output, CORES bits: registered zero flag per core.
REQ-011 SHALL have port Nout, output, CORES bits: registered negative flag (data MSB) per core.
REQ-012 SHALL have port Cout, output, CORES bits: registered carry flag per core.
REQ-013 SHALL have port allZero, output, 1 bit: registered AND of all Zout bits.
REQ-014 SHALL have port anyZero, output, 1 bit: registered OR of all Zout bits.
REQ-015 SHALL have port stickyZ, output, CORES bits: per-core sticky zero-seen flag.
REQ-016 SHALL have port zCount, output, CNT_W bits: saturating count of zero results written.

Function
REQ-017 On a rising edge with wrEn[i]=1, Zout[i] SHALL be 1 if and only if the core-i word of dataIn equals 0.
REQ-018 On the same edge, Nout[i] SHALL take dataIn bit i*WIDTH+WIDTH-1 and Cout[i] SHALL take carryIn[i].
REQ-019 With wrEn[i]=0, Zout[i], Nout[i] and Cout[i] SHALL hold their values.
REQ-020 Flag latency SHALL be one cycle from the input edge to the output; no combinational path from dataIn to any output.
REQ-021 allZero and anyZero SHALL be computed from the next-state Zout vector and registered, so they change on the same edge as Zout.
REQ-022 zCount SHALL increment on each edge by the number of cores with wrEn[i]=1 and a zero word.
REQ-023 zCount SHALL saturate at 2^CNT_W-1 and never wrap; a multi-core increment past the maximum SHALL clamp to the maximum.
REQ-024 clrEn=1 SHALL reset zCount to 0 on the next edge, overriding any increment in the same cycle.
REQ-025 clrEn SHALL NOT affect Zout, Nout, Cout, allZero or anyZero; flag writes in a clrEn cycle SHALL proceed normally.
REQ-026 CORES=1 SHALL be legal; allZero and anyZero then equal Zout[0].

Reset
REQ-027 While rst=0, Zout, Nout, Cout, stickyZ and zCount SHALL be 0, allZero SHALL be 0 and anyZero SHALL be 0, independent of clk.
REQ-028 Reset assertion mid-operation SHALL discard all state immediately.
REQ-029 The first edge after rst deasserts SHALL behave as a normal update edge.

Configuration
REQ-030 Macro STATUS_STICKY_ZERO_EN SHALL, when defined, set stickyZ[i] on any edge where Zout[i] is written as 1; the bit holds until clrEn or reset; clrEn dominates a same-cycle set.
REQ-031 Without STATUS_STICKY_ZERO_EN, stickyZ SHALL be constant 0 and SHALL instantiate no storage.

Verification
REQ-032 Reset, CORES=4: rst=0 mid-run with flags set -> all outputs 0 immediately; first edge after release with wrEn=4'b0001, core0=0 -> Zout=0001, anyZero=1, allZero=0.
REQ-033 Flags: wrEn=4'b1111, words {0x800,0,0x001,0}, carryIn=4'b0101 -> next edge Zout=1010, Nout=0001 (core 0 MSB set), Cout=0101.
REQ-034 Hold: write all zero, then wrEn=0 with dataIn=0xFFF on all cores for 5 cycles -> Zout=1111 and allZero=1 unchanged.
REQ-035 Saturation, CNT_W=3: zCount=6, then write 4 zero words in one cycle -> zCount=7; further zero writes -> stays 7.
REQ-036 Clear priority: clrEn=1 with wrEn=4'b0001 and core0=0 -> zCount=0, Zout[0]=1, stickyZ[0]=0 (macro defined) or 0 (undefined).
REQ-037 Random: 1000 cycles of random dataIn/wrEn/clrEn/rst compared against a reference model each cycle -> zero mismatches.
